// File: rtl/adder_seq_ctrl_pkg.sv
// Shared types and helpers for the chunk-serial shared-adder controller.
package adder_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Ceiling log2 usable in constant expressions; clog2(1) = 0.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/adder_seq_ctrl_adder.sv
// Plain combinational ripple adder slice; the controller time-shares one instance.
module adder #(
  parameter int size = 8
) (
  input  logic [size-1:0] a,
  input  logic [size-1:0] b,
  input  logic            cin,
  output logic [size-1:0] sum,
  output logic            cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{size{1'b0}}, cin};

endmodule

// File: rtl/adder_seq_ctrl.sv
// Round-robin front end plus chunk-serial sequencer around one shared adder slice.
// One WIDTH-bit addition is in flight at a time; the carry ripples between
// chunks through a register, one chunk per cycle.
module adder_seq_ctrl
  import adder_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8,
  parameter int NREQ  = 2,
  localparam int NCHUNK = WIDTH / CHUNK,
  localparam int IDW    = (NREQ > 1) ? clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ-1:0]       req_cin,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_sum,
  output logic                  rsp_cout
);

  localparam int CW = (NCHUNK > 1) ? clog2(NCHUNK) : 1;

  state_t                          state;
  logic [IDW-1:0]                  rr;
  logic [CW-1:0]                   cnt;
  logic [NREQ-1:0][WIDTH-1:0]      a_arr, b_arr;
  logic [NCHUNK-1:0][CHUNK-1:0]    a_r, b_r, sum_r;
  logic                            carry;

  logic                            gnt_vld;
  logic [IDW-1:0]                  gnt_id;
  logic [IDW-1:0]                  rr_nxt;
  logic [IDW-1:0]                  idx;
  int                              tmp;

  logic [CHUNK-1:0]                add_s;
  logic                            add_co;
  logic                            last;

  assign a_arr   = req_a;
  assign b_arr   = req_b;
  assign rsp_sum = sum_r;
  assign last    = (cnt == CW'(NCHUNK - 1));

  // Grant the first valid requester at or after the rr pointer, wrapping.
  // Scanning from the far end lets the nearest hit win.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    tmp     = 0;
    idx     = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      tmp = int'(rr) + k;
      if (tmp >= NREQ) tmp = tmp - NREQ;
      idx = IDW'(tmp);
      if (req_valid[idx]) begin
        gnt_vld = 1'b1;
        gnt_id  = idx;
      end
    end
  end

  // Pointer moves one past the winner so it becomes lowest priority next time.
  assign rr_nxt = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);

  // Ready is offered only to the winner while idle; held low during reset.
  always_comb begin
    req_ready = '0;
    if (rst_n && state == IDLE && gnt_vld) req_ready[gnt_id] = 1'b1;
  end

  adder #(.size(CHUNK)) u_adder (
    .a    (a_r[cnt]),
    .b    (b_r[cnt]),
    .cin  (carry),
    .sum  (add_s),
    .cout (add_co)
  );

  // Controller FSM: accept, ripple chunk by chunk, then hold the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr        <= '0;
      cnt       <= '0;
      a_r       <= '0;
      b_r       <= '0;
      sum_r     <= '0;
      carry     <= 1'b0;
      rsp_id    <= '0;
      rsp_cout  <= 1'b0;
      rsp_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_vld) begin
            a_r    <= a_arr[gnt_id];
            b_r    <= b_arr[gnt_id];
            carry  <= req_cin[gnt_id];  // carry reg doubles as cin for chunk 0
            rsp_id <= gnt_id;
            cnt    <= '0;
            rr     <= rr_nxt;
            state  <= CALC;
          end
        end
        CALC: begin
          sum_r[cnt] <= add_s;
          carry      <= add_co;
          cnt        <= cnt + CW'(1);
          if (last) begin
            cnt       <= '0;
            rsp_cout  <= add_co;
            rsp_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Directed bench for adder_seq_ctrl at WIDTH=32, CHUNK=8, NREQ=2.
module tb_adder_seq_ctrl;

  logic              clk;
  logic              rst_n;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [1:0][31:0]  op_a, op_b;
  logic [1:0]        req_cin;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [0:0]        rsp_id;
  logic [31:0]       rsp_sum;
  logic              rsp_cout;

  int checks = 0;
  int errors = 0;

  adder_seq_ctrl #(.WIDTH(32), .CHUNK(8), .NREQ(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (op_a),
    .req_b     (op_b),
    .req_cin   (req_cin),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Raise one request, wait for its grant, then count negedges until rsp_valid.
  // lat = -1 when grant or response never shows up.
  task automatic issue(input logic id, input logic [31:0] a, input logic [31:0] b,
                       input logic c, output int lat);
    bit got;
    @(posedge clk); #1;
    op_a[id] = a; op_b[id] = b; req_cin[id] = c; req_valid[id] = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (req_ready[id]) got = 1'b1;
    end
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
    lat = -1;
    if (got)
      for (int n = 1; n <= 20 && lat < 0; n++) begin
        @(negedge clk);
        if (rsp_valid) lat = n;
      end
  endtask

  // Let the pending response handshake, then look one cycle later.
  task automatic drain();
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 2'b11; rsp_ready = 1'b1;
    op_a = '0; op_b = '0; req_cin = '0;
    repeat (2) @(negedge clk);
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready got %b exp 00", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
    checks++; if (rsp_sum !== 32'h0 || rsp_id !== 1'b0 || rsp_cout !== 1'b0) begin
      errors++; $display("FAIL reset_outputs got sum %h id %0d cout %b exp 0", rsp_sum, rsp_id, rsp_cout); end
    req_valid = 2'b00;
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int lat;
    issue(1'b0, 32'h12345678, 32'h11111111, 1'b0, lat);
    checks++; if (lat !== 5) begin errors++; $display("FAIL basic_latency got %0d exp 5", lat); end
    checks++; if (rsp_sum !== 32'h23456789) begin errors++; $display("FAIL basic_sum got %h exp 23456789", rsp_sum); end
    checks++; if (rsp_cout !== 1'b0 || rsp_id !== 1'b0) begin
      errors++; $display("FAIL basic_cout_id got cout %b id %0d exp 0 0", rsp_cout, rsp_id); end
    drain();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL basic_rsp_clear got %b exp 0", rsp_valid); end
  endtask

  task automatic test_carry_chain();
    int lat;
    issue(1'b1, 32'hFFFFFFFF, 32'h00000000, 1'b1, lat);
    checks++; if (lat !== 5) begin errors++; $display("FAIL carry_latency got %0d exp 5", lat); end
    checks++; if (rsp_sum !== 32'h0 || rsp_cout !== 1'b1 || rsp_id !== 1'b1) begin
      errors++; $display("FAIL carry_chain got sum %h cout %b id %0d exp 00000000 1 1", rsp_sum, rsp_cout, rsp_id); end
    drain();
  endtask

  task automatic test_fairness();
    int gcnt, lat;
    int gid[4];
    int gcyc[4];
    logic [31:0] exp;
    gcnt = 0;
    @(posedge clk); #1;
    op_a[0] = 32'd1;   op_b[0] = 32'd2;   req_cin[0] = 1'b0;
    op_a[1] = 32'd100; op_b[1] = 32'd200; req_cin[1] = 1'b0;
    rsp_ready = 1'b1; req_valid = 2'b11;
    for (int c = 0; c < 60 && gcnt < 4; c++) begin
      @(negedge clk);
      if (rsp_valid) begin
        exp = rsp_id ? 32'd300 : 32'd3;
        checks++; if (rsp_sum !== exp) begin errors++; $display("FAIL rr_sum id %0d got %h exp %h", rsp_id, rsp_sum, exp); end
      end
      if (req_ready !== 2'b00) begin
        checks++; if (req_ready === 2'b11) begin errors++; $display("FAIL rr_onehot got %b exp one-hot", req_ready); end
        gid[gcnt] = req_ready[1] ? 1 : 0;
        gcyc[gcnt] = c;
        gcnt++;
      end
    end
    @(posedge clk); #1 req_valid = 2'b00;
    lat = -1;
    for (int n = 1; n <= 20 && lat < 0; n++) begin @(negedge clk); if (rsp_valid) lat = n; end
    checks++; if (lat !== 5 || rsp_sum !== 32'd300) begin
      errors++; $display("FAIL rr_last got lat %0d sum %h exp 5 0000012c", lat, rsp_sum); end
    drain();
    checks++; if (gcnt !== 4) begin errors++; $display("FAIL rr_grant_count got %0d exp 4", gcnt); end
    else begin
      for (int k = 0; k < 4; k++) begin
        checks++; if (gid[k] !== (k % 2)) begin errors++; $display("FAIL rr_order grant %0d got %0d exp %0d", k, gid[k], k % 2); end
      end
      for (int k = 1; k < 4; k++) begin
        checks++; if (gcyc[k] - gcyc[k-1] !== 6) begin
          errors++; $display("FAIL rr_spacing grant %0d got %0d exp 6", k, gcyc[k] - gcyc[k-1]); end
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    rsp_ready = 1'b0;
    issue(1'b0, 32'h0000FFFF, 32'h00000001, 1'b0, lat);
    checks++; if (lat !== 5 || rsp_sum !== 32'h00010000) begin
      errors++; $display("FAIL bp_first got lat %0d sum %h exp 5 00010000", lat, rsp_sum); end
    req_valid = 2'b11;
    op_a[1] = 32'hDEADBEEF;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b1 || rsp_sum !== 32'h00010000 || rsp_id !== 1'b0 || rsp_cout !== 1'b0) begin
        errors++; $display("FAIL bp_hold cyc %0d got v %b sum %h id %0d cout %b exp 1 00010000 0 0",
                           n, rsp_valid, rsp_sum, rsp_id, rsp_cout); end
      checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL bp_req_ready cyc %0d got %b exp 00", n, req_ready); end
    end
    req_valid = 2'b00;
    drain();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_release got %b exp 0", rsp_valid); end
  endtask

  task automatic test_async_reset();
    int lat;
    bit got;
    @(posedge clk); #1;
    op_a[0] = 32'hAAAAAAAA; op_b[0] = 32'h55555555; req_cin[0] = 1'b1; req_valid[0] = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin @(negedge clk); if (req_ready[0]) got = 1'b1; end
    checks++; if (!got) begin errors++; $display("FAIL ar_grant got none exp grant 0"); end
    @(posedge clk); #1 req_valid = 2'b00;   // now CALC with cnt=0
    @(posedge clk);                          // cnt=1
    @(posedge clk);                          // cnt=2
    #2 rst_n = 1'b0; req_valid = 2'b11;
    #1;
    checks++; if (rsp_valid !== 1'b0 || rsp_sum !== 32'h0 || rsp_id !== 1'b0 || rsp_cout !== 1'b0 || req_ready !== 2'b00) begin
      errors++; $display("FAIL ar_outputs got v %b sum %h id %0d cout %b rdy %b exp all 0",
                         rsp_valid, rsp_sum, rsp_id, rsp_cout, req_ready); end
    @(negedge clk);
    req_valid = 2'b00;
    rst_n = 1'b1;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL ar_stale cyc %0d got %b exp 0", n, rsp_valid); end
    end
    rsp_ready = 1'b1;
    issue(1'b1, 32'h0F0F0F0F, 32'h01010101, 1'b1, lat);
    checks++; if (lat !== 5 || rsp_sum !== 32'h10101011 || rsp_cout !== 1'b0 || rsp_id !== 1'b1) begin
      errors++; $display("FAIL ar_after got lat %0d sum %h cout %b id %0d exp 5 10101011 0 1", lat, rsp_sum, rsp_cout, rsp_id); end
    drain();
  endtask

  task automatic test_boundaries();
    int lat;
    issue(1'b0, 32'h80000000, 32'h80000000, 1'b0, lat);
    checks++; if (lat !== 5 || rsp_sum !== 32'h0 || rsp_cout !== 1'b1 || rsp_id !== 1'b0) begin
      errors++; $display("FAIL msb_carry got lat %0d sum %h cout %b id %0d exp 5 00000000 1 0", lat, rsp_sum, rsp_cout, rsp_id); end
    drain();
    issue(1'b1, 32'h7FFFFFFF, 32'h00000001, 1'b0, lat);
    checks++; if (lat !== 5 || rsp_sum !== 32'h80000000 || rsp_cout !== 1'b0 || rsp_id !== 1'b1) begin
      errors++; $display("FAIL msb_ovf got lat %0d sum %h cout %b id %0d exp 5 80000000 0 1", lat, rsp_sum, rsp_cout, rsp_id); end
    drain();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry_chain();
    test_fairness();
    test_backpressure();
    test_async_reset();
    test_boundaries();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
